// File: rtl/uart_rx_if.sv
// Serial-line side of the UART receiver: line and tick in, byte and status pulses out.
// The master modport is the driving side (line/tick source); slave is the receiver.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            i_rx;
    logic            i_s_tick;
    logic [DBIT-1:0] o_data;
    logic            o_rx_done;
    logic            o_frame_error;
    logic            o_busy;

    modport master (
        output i_rx, i_s_tick,
        input  o_data, o_rx_done, o_frame_error, o_busy
    );

    modport slave (
        input  i_rx, i_s_tick,
        output o_data, o_rx_done, o_frame_error, o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start/DBIT data (LSB first)/stop, mid-bit sampling,
// one-cycle done or frame-error pulse per frame, BREAK state to ride out a held-low line.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input logic       i_clk,
    input logic       i_reset,
    uart_rx_if.slave  bus
);
    // Stop-bit counting needs a fifth bit once it runs past 16 ticks.
    localparam int SW = (SB_TICK > 16) ? 5 : 4;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t          state_q, state_n;
    logic [SW-1:0]   s_cnt_q, s_cnt_n;
    logic [2:0]      n_cnt_q, n_cnt_n;
    logic [DBIT-1:0] shift_q, shift_n;
    logic [DBIT-1:0] data_q, data_n;
    logic            done_q, done_n;
    logic            ferr_q, ferr_n;
    logic            busy;
    logic [1:0]      sync_q;
    logic            rx_s;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], bus.i_rx};
    end
    assign rx_s = sync_q[1];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            s_cnt_q <= s_cnt_n;
            n_cnt_q <= n_cnt_n;
            shift_q <= shift_n;
            data_q  <= data_n;
            done_q  <= done_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state_q;
        s_cnt_n = s_cnt_q;
        n_cnt_n = n_cnt_q;
        shift_n = shift_q;
        data_n  = data_q;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (bus.i_s_tick) begin
                    if (s_cnt_q == SW'(7)) begin
                        s_cnt_n = '0;
                        n_cnt_n = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        s_cnt_n = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.i_s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        s_cnt_n = '0;
                        shift_n = {rx_s, shift_q[DBIT-1:1]};
                        if (n_cnt_q == 3'(DBIT-1)) state_n = STOP;
                        else                       n_cnt_n = n_cnt_q + 1'b1;
                    end else begin
                        s_cnt_n = s_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.i_s_tick) begin
                    if (s_cnt_q == SW'(SB_TICK-1)) begin
                        s_cnt_n = '0;
                        if (rx_s) begin
                            data_n  = shift_q;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BRK;
                        end
                    end else begin
                        s_cnt_n = s_cnt_q + 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    assign bus.o_data        = data_q;
    assign bus.o_rx_done     = done_q;
    assign bus.o_frame_error = ferr_q;
    assign bus.o_busy        = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean, back-to-back, glitch, framing error, break and reset-mid-frame.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tcnt = 2'd0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] got[$];
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, changed on the falling edge so it is stable at the rising edge.
    initial bus.i_s_tick = 1'b0;
    always @(negedge clk) begin
        tcnt = tcnt + 2'd1;
        bus.i_s_tick = (tcnt == 2'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.o_rx_done || bus.o_frame_error)) begin
            chk("pulse_excl_1cyc",
                {31'd0, (bus.o_rx_done && bus.o_frame_error) || (bus.o_rx_done && prev_done)
                        || (bus.o_frame_error && prev_ferr)}, 32'd0);
            if (bus.o_rx_done) begin
                done_cnt++;
                got.push_back(bus.o_data);
            end
            if (bus.o_frame_error) ferr_cnt++;
        end
        prev_done = bus.o_rx_done;
        prev_ferr = bus.o_frame_error;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bus.i_s_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            bus.i_rx = b[i];
            wait_ticks(16);
        end
        bus.i_rx = stop;
        wait_ticks(16);
        if (stop) bus.i_rx = 1'b1;
    endtask

    task automatic chk_pop(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        if (got.size() > 0) v = got.pop_front();
        else                v = 8'hxx;
        chk(tag, {24'd0, v}, {24'd0, exp});
    endtask

    initial begin
        int d0;
        int f0;
        bus.i_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, bus.o_data}, 32'h00);
        chk("rst_done", {31'd0, bus.o_rx_done}, 32'd0);
        chk("rst_ferr", {31'd0, bus.o_frame_error}, 32'd0);
        chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Clean frame
        send_byte(8'h5A, 1'b1);
        wait_ticks(2);
        chk("clean_done_cnt", done_cnt, 1);
        chk_pop("clean_data", 8'h5A);
        chk("clean_outdata", {24'd0, bus.o_data}, 32'h5A);
        chk("clean_ferr_cnt", ferr_cnt, 0);
        chk("clean_busy", {31'd0, bus.o_busy}, 32'd0);

        // Back-to-back, no idle gap
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h06, 1'b1);
        wait_ticks(2);
        chk("b2b_done_cnt", done_cnt, 4);
        chk_pop("b2b_0", 8'h12);
        chk_pop("b2b_1", 8'h34);
        chk_pop("b2b_2", 8'h06);

        // 3-tick glitch on idle line
        bus.i_rx = 1'b0;
        wait_ticks(3);
        bus.i_rx = 1'b1;
        wait_ticks(2);
        chk("glitch_busy_mid", {31'd0, bus.o_busy}, 32'd1);
        wait_ticks(8);
        chk("glitch_busy_after", {31'd0, bus.o_busy}, 32'd0);
        chk("glitch_done_cnt", done_cnt, 4);
        chk("glitch_data", {24'd0, bus.o_data}, 32'h06);

        // Stop bit low -> framing error
        send_byte(8'h3C, 1'b0);
        chk("ferr_cnt", ferr_cnt, 1);
        chk("ferr_done_cnt", done_cnt, 4);
        chk("ferr_data", {24'd0, bus.o_data}, 32'h06);
        chk("ferr_busy_break", {31'd0, bus.o_busy}, 32'd1);
        bus.i_rx = 1'b1;
        wait_ticks(4);
        chk("ferr_busy_idle", {31'd0, bus.o_busy}, 32'd0);

        // Held-low break then a good frame
        f0 = ferr_cnt;
        d0 = done_cnt;
        bus.i_rx = 1'b0;
        wait_ticks(640);
        chk("brk_ferr_once", ferr_cnt, f0 + 1);
        chk("brk_busy", {31'd0, bus.o_busy}, 32'd1);
        chk("brk_no_done", done_cnt, d0);
        bus.i_rx = 1'b1;
        wait_ticks(16);
        send_byte(8'hA5, 1'b1);
        wait_ticks(2);
        chk("brk_done_cnt", done_cnt, d0 + 1);
        chk_pop("brk_data", 8'hA5);
        chk("brk_ferr_total", ferr_cnt, f0 + 1);

        // Reset in bit 4 of 0xFF
        d0 = done_cnt;
        bus.i_rx = 1'b0;
        wait_ticks(16);
        bus.i_rx = 1'b1;
        wait_ticks(72);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid_data", {24'd0, bus.o_data}, 32'h00);
        chk("rstmid_busy", {31'd0, bus.o_busy}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(100);
        chk("rstmid_no_done", done_cnt, d0);
        chk("rstmid_data_after", {24'd0, bus.o_data}, 32'h00);
        send_byte(8'h81, 1'b1);
        wait_ticks(2);
        chk("rstmid_done_cnt", done_cnt, d0 + 1);
        chk_pop("rstmid_0x81", 8'h81);
        chk("final_ferr_total", ferr_cnt, f0 + 1);
        chk("final_queue_empty", got.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
